// File: rtl/eco32f_div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// The EX stage drives the request side (master); the divider answers (slave).
interface eco32f_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output flush, start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  flush, start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/eco32f_div_unit.sv
// Iterative restoring divider for the eco32f EX stage. Retires BPC quotient
// bits per clock, fixes signs in a final cycle, and pulses done with
// registered quotient/remainder. busy feeds the EX stall logic.
module eco32f_div_unit #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic               clk,
   input  logic               rst,
   eco32f_div_unit_if.slave   bus
);

   localparam int N  = WIDTH / BPC;
   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   if (WIDTH < 2 || !(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0) begin : g_param_check
      $error("eco32f_div_unit: illegal WIDTH/BPC combination");
   end

   // BPC chained restoring steps. The shifted remainder is kept W+1 bits wide
   // so a remainder with its MSB set (divisor above 2^(W-1)) is not truncated.
   function automatic logic [2*WIDTH-1:0] div_step(
      input logic [WIDTH-1:0] rem_in,
      input logic [WIDTH-1:0] quo_in,
      input logic [WIDTH-1:0] dsr
   );
      logic [WIDTH:0]   v_sh;
      logic [WIDTH:0]   v_diff;
      logic [WIDTH-1:0] v_r;
      logic [WIDTH-1:0] v_n;
      v_r = rem_in;
      v_n = quo_in;
      for (int i = 0; i < BPC; i++) begin
         v_sh   = {v_r, v_n[WIDTH-1]};
         v_diff = v_sh - {1'b0, dsr};
         v_r    = v_diff[WIDTH] ? v_sh[WIDTH-1:0] : v_diff[WIDTH-1:0];
         v_n    = {v_n[WIDTH-2:0], ~v_diff[WIDTH]};
      end
      return {v_r, v_n};
   endfunction

   // Two's-complement negate modulo 2^WIDTH when neg is set.
   function automatic logic [WIDTH-1:0] cond_neg(
      input logic [WIDTH-1:0] v,
      input logic             neg
   );
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_d;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_dz;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dzo;

   logic             w_accept;
   logic             w_calc;
   logic             w_fix;
   logic             w_dvs_zero;
   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic [2*WIDTH-1:0] w_step;

   assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.flush;
   assign w_calc     = (r_state == S_CALC) && !bus.flush;
   assign w_fix      = (r_state == S_FIX)  && !bus.flush;
   assign w_dvs_zero = (bus.divisor == '0);
   assign w_dvd_neg  = bus.signed_op && bus.dividend[WIDTH-1];
   assign w_dvs_neg  = bus.signed_op && bus.divisor[WIDTH-1];
   assign w_step     = div_step(r_r, r_n, r_d);

   // Control FSM: accept, count CALC cycles, one FIX cycle; flush aborts anywhere.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     r_busy  <= 1'b1;
                     r_cnt   <= CW'(N);
                     r_state <= w_dvs_zero ? S_FIX : S_CALC;
                  end
               end
               S_CALC: begin
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) r_state <= S_FIX;
               end
               S_FIX: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Working datapath: latch magnitudes and sign flags on accept, iterate in CALC.
   // On divide-by-zero r_n keeps the raw dividend for the remainder output.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_n    <= w_dvs_zero ? bus.dividend : cond_neg(bus.dividend, w_dvd_neg);
         r_d    <= cond_neg(bus.divisor, w_dvs_neg);
         r_r    <= '0;
         r_qneg <= w_dvd_neg ^ w_dvs_neg;
         r_rneg <= w_dvd_neg;
         r_dz   <= w_dvs_zero;
      end else if (w_calc) begin
         r_r <= w_step[2*WIDTH-1:WIDTH];
         r_n <= w_step[WIDTH-1:0];
      end
   end

   // Result registers: updated only by an unflushed FIX, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_quot <= '0;
         r_rem  <= '0;
         r_dzo  <= 1'b0;
      end else if (w_fix) begin
         r_quot <= r_dz ? '1  : cond_neg(r_n, r_qneg);
         r_rem  <= r_dz ? r_n : cond_neg(r_r, r_rneg);
         r_dzo  <= r_dz;
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dzo;

endmodule
